// File: rtl/edu_tpu_mvu.sv
// edu_tpu_mvu: NxN weight-stationary matrix-vector unit on the Caravel
// Wishbone bus. Each N-element input vector x produces y = W*x, with
// selectable signed/unsigned arithmetic and optional ReLU.
//
// Ports:
//   caravel_wb_clk_i  single clock, rising edge
//   caravel_wb_rst_i  asynchronous active-low reset
//   caravel_wb_stb_i / cyc_i / we_i / sel_i / dat_i / adr_i  Wishbone slave inputs
//   caravel_wb_ack_o  registered one-cycle acknowledge
//   caravel_wb_dat_o  registered read data, valid while ack is high
//
// Handshake: a bus access is stb & cyc & address in window & !ack. The
// register side effect (push, pop, write) is taken on the same clock edge
// that raises ack and latches read data, so it is visible in the ack cycle
// and happens exactly once per access.
//
// Register map (byte offsets): 0x00 CTRL, 0x04 STATUS, 0x08 WEIGHT,
// 0x0C INPUT, 0x10 RESULT.
module edu_tpu_mvu #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          N            = 3,
    parameter int          DW           = 8,
    parameter int          ACC_W        = 2*DW + $clog2(N),
    parameter int          IN_DEPTH     = 16,
    parameter int          RES_DEPTH    = 16
) (
    input  logic        caravel_wb_clk_i,
    input  logic        caravel_wb_rst_i,
    input  logic        caravel_wb_stb_i,
    input  logic        caravel_wb_cyc_i,
    input  logic        caravel_wb_we_i,
    input  logic [3:0]  caravel_wb_sel_i,
    input  logic [31:0] caravel_wb_dat_i,
    input  logic [31:0] caravel_wb_adr_i,
    output logic        caravel_wb_ack_o,
    output logic [31:0] caravel_wb_dat_o
);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam int CW  = $clog2(N);
    localparam logic [CW-1:0] LAST       = CW'(N - 1);
    localparam logic [IAW:0]  IN_CAP     = (IAW+1)'(IN_DEPTH);
    localparam logic [IAW:0]  N_IN       = (IAW+1)'(N);
    localparam logic [RAW:0]  RES_CAP    = (RAW+1)'(RES_DEPTH);
    localparam logic [RAW:0]  N_RES      = (RAW+1)'(N);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_WRITE} state_e;

    // bus / register state
    logic              ack_q, clr_q, err_q, loaded_q, ctrl_signed_q, ctrl_relu_q;
    logic [31:0]       dat_q;
    logic [CW-1:0]     row_q, col_q;
    logic [DW-1:0]     w_q [N][N];
    // input FIFO
    logic [DW-1:0]     in_mem [IN_DEPTH];
    logic [IAW-1:0]    in_wp_q, in_rp_q;
    logic [IAW:0]      in_cnt_q, in_cnt_d;
    // result FIFO
    logic [31:0]       res_mem [RES_DEPTH];
    logic [RAW-1:0]    res_wp_q, res_rp_q;
    logic [RAW:0]      res_cnt_q, res_cnt_d;
    // engine
    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic              sgn_q, relu_q;
    logic [DW-1:0]     x_q [N];
    logic [ACC_W-1:0]  acc_q [N];

    // ---------------- bus decode ----------------
    logic [31:0] off;
    logic        access, aligned, wr, rd;
    logic        ctrl_wr, stat_wr, w_wr, in_wr, res_rd, rd_ctrl, rd_stat;
    logic        busy, in_full, res_empty, in_push, res_pop, eng_pop, eng_push, start;
    logic        set_err;
    logic [31:0] status, rdata, res_val;
    logic [ACC_W-1:0] y_sel;
    logic        unused_bits;

    assign off     = caravel_wb_adr_i - BASE_ADDRESS;  // wraps high when below base
    assign access  = caravel_wb_stb_i & caravel_wb_cyc_i & (off <= 32'h10) & ~ack_q;
    assign aligned = (off[1:0] == 2'b00);
    assign wr      = access & caravel_wb_we_i & aligned;
    assign rd      = access & ~caravel_wb_we_i & aligned;
    assign ctrl_wr = wr & (off[4:2] == 3'd0);
    assign stat_wr = wr & (off[4:2] == 3'd1);
    assign w_wr    = wr & (off[4:2] == 3'd2);
    assign in_wr   = wr & (off[4:2] == 3'd3);
    assign rd_ctrl = rd & (off[4:2] == 3'd0);
    assign rd_stat = rd & (off[4:2] == 3'd1);
    assign res_rd  = rd & (off[4:2] == 3'd4);

    assign unused_bits = ^{caravel_wb_sel_i, caravel_wb_dat_i};

    assign busy      = (state_q != S_IDLE);
    assign in_full   = (in_cnt_q == IN_CAP);
    assign res_empty = (res_cnt_q == '0);
    assign in_push   = in_wr & ~in_full;
    assign res_pop   = res_rd & ~res_empty;
    assign eng_pop   = (state_q == S_LOAD);
    assign eng_push  = (state_q == S_WRITE);
    assign start     = loaded_q & (in_cnt_q >= N_IN) & ((RES_CAP - res_cnt_q) >= N_RES);
    assign set_err   = (w_wr & busy) | (in_wr & in_full) | (res_rd & res_empty);

    assign status = {16'd0, 8'(res_cnt_q), 3'd0, err_q, loaded_q, res_empty, in_full, busy};

    always_comb begin
        rdata = '0;
        if (rd_ctrl)      rdata = {29'd0, ctrl_relu_q, ctrl_signed_q, 1'b0};
        else if (rd_stat) rdata = status;
        else if (res_pop) rdata = res_mem[res_rp_q];
    end

    // Result for the row being written: ReLU only applies to signed vectors,
    // then the value is extended to 32 bits with the vector's signedness.
    always_comb begin
        y_sel = acc_q[cnt_q];
        if (sgn_q && relu_q && y_sel[ACC_W-1]) y_sel = '0;
        if (sgn_q) res_val = 32'($signed(y_sel));
        else       res_val = 32'(y_sel);
    end

    always_comb begin
        in_cnt_d = in_cnt_q;
        if (in_push && !eng_pop)      in_cnt_d = in_cnt_q + 1'b1;
        else if (!in_push && eng_pop) in_cnt_d = in_cnt_q - 1'b1;
        res_cnt_d = res_cnt_q;
        if (eng_push && !res_pop)      res_cnt_d = res_cnt_q + 1'b1;
        else if (!eng_push && res_pop) res_cnt_d = res_cnt_q - 1'b1;
    end

    function automatic logic [ACC_W-1:0] ext(input logic [DW-1:0] v, input logic s);
        if (s) ext = ACC_W'($signed(v));
        else   ext = ACC_W'(v);
    endfunction

    // ---------------- bus registers and weights ----------------
    always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_i) begin
        if (!caravel_wb_rst_i) begin
            ack_q         <= 1'b0;
            dat_q         <= '0;
            clr_q         <= 1'b0;
            err_q         <= 1'b0;
            loaded_q      <= 1'b0;
            ctrl_signed_q <= 1'b0;
            ctrl_relu_q   <= 1'b0;
            row_q         <= '0;
            col_q         <= '0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) w_q[r][c] <= '0;
        end else begin
            ack_q <= access;
            dat_q <= access ? rdata : 32'd0;
            clr_q <= ctrl_wr & caravel_wb_dat_i[0];
            if (ctrl_wr) begin
                ctrl_signed_q <= caravel_wb_dat_i[1];
                ctrl_relu_q   <= caravel_wb_dat_i[2];
            end
            if (set_err)                             err_q <= 1'b1;
            else if (stat_wr && caravel_wb_dat_i[4]) err_q <= 1'b0;
            if (w_wr && !busy) begin
                w_q[row_q][col_q] <= caravel_wb_dat_i[DW-1:0];
                if (col_q == LAST) begin
                    col_q <= '0;
                    if (row_q == LAST) begin
                        row_q    <= '0;
                        loaded_q <= 1'b1;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    assign caravel_wb_ack_o = ack_q;
    assign caravel_wb_dat_o = dat_q;

    // ---------------- FIFOs ----------------
    always_ff @(posedge caravel_wb_clk_i) begin
        if (in_push)  in_mem[in_wp_q]   <= caravel_wb_dat_i[DW-1:0];
        if (eng_push) res_mem[res_wp_q] <= res_val;
    end

    always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_i) begin
        if (!caravel_wb_rst_i || clr_q) begin
            in_wp_q   <= '0;
            in_rp_q   <= '0;
            in_cnt_q  <= '0;
            res_wp_q  <= '0;
            res_rp_q  <= '0;
            res_cnt_q <= '0;
        end else begin
            if (in_push)  in_wp_q  <= in_wp_q + 1'b1;
            if (eng_pop)  in_rp_q  <= in_rp_q + 1'b1;
            if (eng_push) res_wp_q <= res_wp_q + 1'b1;
            if (res_pop)  res_rp_q <= res_rp_q + 1'b1;
            in_cnt_q  <= in_cnt_d;
            res_cnt_q <= res_cnt_d;
        end
    end

    // ---------------- engine FSM ----------------
    always_ff @(posedge caravel_wb_clk_i or negedge caravel_wb_rst_i) begin
        if (!caravel_wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            relu_q  <= 1'b0;
            for (int r = 0; r < N; r++) begin
                acc_q[r] <= '0;
                x_q[r]   <= '0;
            end
        end else if (clr_q) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            for (int r = 0; r < N; r++) acc_q[r] <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    state_q <= S_LOAD;
                    cnt_q   <= '0;
                    sgn_q   <= ctrl_signed_q;
                    relu_q  <= ctrl_relu_q;
                    for (int r = 0; r < N; r++) acc_q[r] <= '0;
                end
                S_LOAD: begin
                    x_q[cnt_q] <= in_mem[in_rp_q];
                    cnt_q      <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= S_MAC;
                end
                S_MAC: begin
                    // column cnt_q of W times x[cnt_q], all rows in parallel
                    for (int r = 0; r < N; r++)
                        acc_q[r] <= acc_q[r] + ext(w_q[r][cnt_q], sgn_q) * ext(x_q[cnt_q], sgn_q);
                    cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= S_WRITE;
                end
                default: begin
                    cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_edu_tpu_mvu.sv
module tb_edu_tpu_mvu;
    localparam int N     = 3;
    localparam int DW    = 8;
    localparam int ACC_W = 2*DW + $clog2(N);
    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_STATUS = BASE + 32'h04;
    localparam logic [31:0] A_WEIGHT = BASE + 32'h08;
    localparam logic [31:0] A_INPUT  = BASE + 32'h0C;
    localparam logic [31:0] A_RESULT = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] dat_i = '0, adr = '0;
    logic        ack;
    logic [31:0] dat_o;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];
    int w_m[N*N];
    int x_m[N];

    edu_tpu_mvu dut (
        .caravel_wb_clk_i(clk),
        .caravel_wb_rst_i(rst_n),
        .caravel_wb_stb_i(stb),
        .caravel_wb_cyc_i(cyc),
        .caravel_wb_we_i (we),
        .caravel_wb_sel_i(sel),
        .caravel_wb_dat_i(dat_i),
        .caravel_wb_adr_i(adr),
        .caravel_wb_ack_o(ack),
        .caravel_wb_dat_o(dat_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] r);
        logic got;
        got = 1'b0;
        r = '0;
        @(posedge clk); #1;
        adr = a; dat_i = d; we = w; stb = 1'b1; cyc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                got = 1'b1;
                r = dat_o;
                break;
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        if (!got) begin
            tests_run++; tests_failed++;
            $display("FAIL bus_ack: addr %h got no ack, required ack within 8 cycles", a);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(1'b1, a, d, dummy);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r);
        bus_xfer(1'b0, a, 32'd0, r);
    endtask

    task automatic load_weights();
        for (int i = 0; i < N*N; i++) wr(A_WEIGHT, 32'(w_m[i]));
    endtask

    task automatic push_inputs();
        for (int k = 0; k < N; k++) wr(A_INPUT, 32'(x_m[k]));
    endtask

    // Reference: y[r] = sum_k W[r][k]*x[k], modulo 2^ACC_W, ReLU on signed only.
    function automatic logic [31:0] model(input int r, input bit sgn, input bit relu);
        logic signed [63:0] s, a, b, m;
        s = 0;
        for (int k = 0; k < N; k++) begin
            a = w_m[r*N+k] & 255;
            b = x_m[k] & 255;
            if (sgn && a > 127) a = a - 256;
            if (sgn && b > 127) b = b - 256;
            s = s + a * b;
        end
        m = (64'sd1 <<< ACC_W) - 1;
        s = s & m;
        if (sgn && s[ACC_W-1]) begin
            if (relu) return 32'd0;
            s = s - (64'sd1 <<< ACC_W);
        end
        return s[31:0];
    endfunction

    task automatic push_vec(input bit sgn, input bit relu);
        push_inputs();
        for (int r = 0; r < N; r++) exp_q.push_back(model(r, sgn, relu));
    endtask

    // ---------------- scoreboard ----------------
    task automatic wait_count(input int n);
        logic [31:0] st;
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            rd(A_STATUS, st);
            if (int'(st[15:8]) >= n) ok = 1;
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL result_count: got %0d results, required %0d", st[15:8], n);
        end
    endtask

    task automatic drain(input int n);
        logic [31:0] got, e;
        wait_count(n);
        for (int i = 0; i < n; i++) begin
            rd(A_RESULT, got);
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL result_extra: got %h with empty expected queue", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    tests_failed++;
                    $display("FAIL result[%0d]: got %h required %h", i, got, e);
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] r;
        tests_run++;
        if (ack !== 1'b0 || dat_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ack=%b dat=%h required ack=0 dat=0", ack, dat_o);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        rd(A_STATUS, r);
        tests_run++;
        if (r !== 32'h4) begin
            tests_failed++;
            $display("FAIL reset_status: got %h required %h", r, 32'h4);
        end
        rd(A_CTRL, r);
        tests_run++;
        if (r !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %h required 0", r);
        end
    endtask

    task automatic test_unsigned();
        logic [31:0] r;
        for (int i = 0; i < N*N; i++) w_m[i] = i + 1;
        load_weights();
        rd(A_STATUS, r);
        tests_run++;
        if (r !== 32'hC) begin
            tests_failed++;
            $display("FAIL loaded_status: got %h required %h", r, 32'hC);
        end
        for (int k = 0; k < N; k++) x_m[k] = 1;
        push_vec(0, 0);
        drain(N);
        rd(A_STATUS, r);
        tests_run++;
        if (r !== 32'hC) begin
            tests_failed++;
            $display("FAIL unsigned_done_status: got %h required %h", r, 32'hC);
        end
    endtask

    task automatic test_signed();
        logic [31:0] r;
        wr(A_CTRL, 32'h2);
        x_m[0] = 8'hFF; x_m[1] = 0; x_m[2] = 0;
        push_vec(1, 0);
        drain(N);
        wr(A_CTRL, 32'h6);
        push_vec(1, 1);
        drain(N);
        rd(A_CTRL, r);
        tests_run++;
        if (r !== 32'h6) begin
            tests_failed++;
            $display("FAIL ctrl_readback: got %h required %h", r, 32'h6);
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_unmapped();
        logic [31:0] r;
        rd(A_WEIGHT, r);
        tests_run++;
        if (r !== 32'h0) begin
            tests_failed++;
            $display("FAIL read_weight_reg: got %h required 0", r);
        end
        rd(BASE + 32'h2, r);
        tests_run++;
        if (r !== 32'h0) begin
            tests_failed++;
            $display("FAIL unaligned_read: got %h required 0", r);
        end
        wr(A_RESULT, 32'h5);
        rd(A_STATUS, r);
        tests_run++;
        if (r !== 32'hC) begin
            tests_failed++;
            $display("FAIL write_result_reg: status %h required %h", r, 32'hC);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        bit sgn, relu;
        sgn  = 1'($urandom_range(0, 1));
        relu = 1'($urandom_range(0, 1));
        for (int i = 0; i < N*N; i++) w_m[i] = int'($urandom_range(0, 255));
        load_weights();
        wr(A_CTRL, {29'd0, relu, sgn, 1'b0});
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < N; k++) x_m[k] = int'($urandom_range(0, 255));
            push_vec(sgn, relu);
        end
        drain(4*N);
        rd(A_STATUS, r);
        tests_run++;
        if (r !== 32'hC) begin
            tests_failed++;
            $display("FAIL b2b_done_status: got %h required %h", r, 32'hC);
        end
        wr(A_CTRL, 32'h0);
    endtask

    task automatic test_weight_during_mac();
        logic [31:0] r;
        for (int i = 0; i < N*N; i++) w_m[i] = i + 1;
        load_weights();
        for (int k = 0; k < N; k++) x_m[k] = 1;
        push_vec(0, 0);
        repeat (3) @(posedge clk);
        wr(A_WEIGHT, 32'd99);
        rd(A_STATUS, r);
        tests_run++;
        if (r[4] !== 1'b1) begin
            tests_failed++;
            $display("FAIL weight_busy_err: status %h required ERR bit set", r);
        end
        drain(N);
        wr(A_STATUS, 32'h10);
        rd(A_STATUS, r);
        tests_run++;
        if (r !== 32'hC) begin
            tests_failed++;
            $display("FAIL err_clear: got %h required %h", r, 32'hC);
        end
    endtask

    task automatic test_soft_clr_abort();
        logic [31:0] r;
        for (int k = 0; k < N; k++) x_m[k] = 1;
        push_inputs();
        repeat (3) @(posedge clk);
        wr(A_CTRL, 32'h1);
        repeat (20) @(posedge clk);
        rd(A_STATUS, r);
        tests_run++;
        if (r !== 32'hC) begin
            tests_failed++;
            $display("FAIL soft_clr_status: got %h required %h", r, 32'hC);
        end
        push_vec(0, 0);
        drain(N);
    endtask

    task automatic test_err_full();
        logic [31:0] r;
        do_reset();
        for (int i = 0; i < 17; i++) wr(A_INPUT, 32'(i));
        rd(A_STATUS, r);
        tests_run++;
        if (r !== 32'h16) begin
            tests_failed++;
            $display("FAIL full_status: got %h required %h", r, 32'h16);
        end
        wr(A_STATUS, 32'h10);
        rd(A_STATUS, r);
        tests_run++;
        if (r !== 32'h6) begin
            tests_failed++;
            $display("FAIL full_err_clear: got %h required %h", r, 32'h6);
        end
        rd(A_RESULT, r);
        tests_run++;
        if (r !== 32'h0) begin
            tests_failed++;
            $display("FAIL empty_read: got %h required 0", r);
        end
        rd(A_STATUS, r);
        tests_run++;
        if (r !== 32'h16) begin
            tests_failed++;
            $display("FAIL empty_read_err: got %h required %h", r, 32'h16);
        end
        wr(A_CTRL, 32'h1);
        repeat (2) @(posedge clk);
        rd(A_STATUS, r);
        tests_run++;
        if (r !== 32'h14) begin
            tests_failed++;
            $display("FAIL soft_clr_flush: got %h required %h", r, 32'h14);
        end
        wr(A_STATUS, 32'h10);
        rd(A_STATUS, r);
        tests_run++;
        if (r !== 32'h4) begin
            tests_failed++;
            $display("FAIL final_err_clear: got %h required %h", r, 32'h4);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r;
        for (int i = 0; i < N*N; i++) w_m[i] = i + 1;
        load_weights();
        for (int k = 0; k < N; k++) x_m[k] = 1;
        push_inputs();
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (ack !== 1'b0 || dat_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL abort_outputs: ack=%b dat=%h required 0/0", ack, dat_o);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        rd(A_STATUS, r);
        tests_run++;
        if (r !== 32'h4) begin
            tests_failed++;
            $display("FAIL abort_status: got %h required %h", r, 32'h4);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        #12;
        test_reset();
        test_unsigned();
        test_signed();
        test_unmapped();
        test_back_to_back();
        test_weight_during_mac();
        test_soft_clr_abort();
        test_err_full();
        test_reset_abort();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL leftover_expected: got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
